// File: rtl/unidad_acceso_mem_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package unidad_acceso_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_LD_WAIT   = 2'b01,
        ST_RMW_MERGE = 2'b10
    } state_e;

endpackage

// File: rtl/unidad_acceso_mem_alineador_datos.sv
// alineador_datos: combinational lane handling for the load/store unit.
//   mem_word_i   word read from memory
//   addr_lo_i    byte offset within the word (little-endian)
//   size_i       access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   signed_i     load sign-extension select
//   wdata_i      right-justified store data
//   load_data_o  extracted and extended load value
//   merged_o     mem_word_i with the target lane replaced by wdata_i
module alineador_datos
    import unidad_acceso_mem_pkg::*;
(
    input  logic [31:0] mem_word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = mem_word_i[{addr_lo_i, 3'b000} +: 8];
        lane_h = mem_word_i[{addr_lo_i[1], 4'b0000} +: 16];

        case (size_i)
            SZ_BYTE: load_data_o = {{24{signed_i & lane_b[7]}}, lane_b};
            SZ_HALF: load_data_o = {{16{signed_i & lane_h[15]}}, lane_h};
            default: load_data_o = mem_word_i;
        endcase

        merged_o = mem_word_i;
        case (size_i)
            SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]       = wdata_i[7:0];
            SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16]  = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/unidad_acceso_mem.sv
// unidad_acceso_mem: load/store unit in front of a word-wide data memory.
//   Core side : req_valid/req_write/req_size/req_signed/req_addr/req_wdata in,
//               stall, rdata, rdata_valid, acc_err out.
//   Memory    : EscrMem/LeerMem strobes, Direc word address, Datain write data,
//               Dataout read data (valid the cycle after LeerMem).
// Word stores complete in the request cycle; loads and sub-word stores take
// two cycles (read, then extract or read-modify-write).
//
// state        | meaning
// ST_IDLE      | accepting a request; error check, word store, or issue read
// ST_LD_WAIT   | read data on Dataout; extract, extend, pulse rdata_valid
// ST_RMW_MERGE | read data on Dataout; merge store lane and write back
module unidad_acceso_mem
    import unidad_acceso_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  stall,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_valid,
    output logic                  acc_err,
    output logic                  EscrMem,
    output logic                  LeerMem,
    output logic [DEPTH_LOG2-1:0] Direc,
    output logic [DATA_W-1:0]     Datain,
    input  logic [DATA_W-1:0]     Dataout
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   merged;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                req_err;

    assign word_idx = req_addr[DEPTH_LOG2+1:2];

    assign req_err = (req_size == SZ_RSVD)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (|req_addr[1:0]))
                   | (|req_addr[31:DEPTH_LOG2+2]);

    alineador_datos u_alineador (
        .mem_word_i  (Dataout),
        .addr_lo_i   (req_addr[1:0]),
        .size_i      (req_size),
        .signed_i    (req_signed),
        .wdata_i     (req_wdata),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    // Outputs are gated by rst so an access interrupted by reset never
    // reaches the memory, even while the core still holds its request.
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        rdata       = rdata_q;
        stall       = 1'b0;
        rdata_valid = 1'b0;
        acc_err     = 1'b0;
        EscrMem     = 1'b0;
        LeerMem     = 1'b0;
        Direc       = '0;
        Datain      = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_err) begin
                            acc_err = 1'b1;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            EscrMem = 1'b1;
                            Direc   = word_idx;
                            Datain  = req_wdata;
                        end else begin
                            LeerMem = 1'b1;
                            stall   = 1'b1;
                            Direc   = word_idx;
                            state_d = req_write ? ST_RMW_MERGE : ST_LD_WAIT;
                        end
                    end
                end
                ST_LD_WAIT: begin
                    rdata       = load_data;
                    rdata_d     = load_data;
                    rdata_valid = 1'b1;
                    state_d     = ST_IDLE;
                end
                ST_RMW_MERGE: begin
                    EscrMem = 1'b1;
                    Direc   = word_idx;
                    Datain  = merged;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_unidad_acceso_mem.sv
module tb_unidad_acceso_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rdata_valid, acc_err, EscrMem, LeerMem;
    logic [31:0] rdata, Datain;
    logic [31:0] Dataout;
    logic [7:0]  Direc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    unidad_acceso_mem dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .acc_err(acc_err),
        .EscrMem(EscrMem), .LeerMem(LeerMem), .Direc(Direc), .Datain(Datain),
        .Dataout(Dataout)
    );

    // Data memory model: synchronous write, registered read.
    logic [31:0] mem [256];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            Dataout <= 32'h0;
        end else begin
            if (EscrMem) mem[Direc] <= Datain;
            if (LeerMem) Dataout <= mem[Direc];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobe exclusivity and single-cycle stall, every cycle out of reset.
    logic stall_prev = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("strobe_overlap", {31'b0, EscrMem & LeerMem}, 32'h0);
            chk("stall_run", {31'b0, stall & stall_prev}, 32'h0);
            stall_prev <= stall;
        end else begin
            stall_prev <= 1'b0;
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    // Enters at posedge+1, leaves at posedge+1 of the cycle after completion.
    task automatic apply(input vec_t v, input string tag);
        logic [7:0] idx;
        idx = v.addr[9:2];
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(negedge clk);
        if (v.err) begin
            chk({tag, " err"},   {31'b0, acc_err}, 32'h1);
            chk({tag, " stall"}, {31'b0, stall},   32'h0);
            chk({tag, " strobes"}, {30'b0, EscrMem, LeerMem}, 32'h0);
        end else if (v.wr && v.size == 2'b10) begin
            chk({tag, " c0 EscrMem"}, {31'b0, EscrMem}, 32'h1);
            chk({tag, " c0 LeerMem"}, {31'b0, LeerMem}, 32'h0);
            chk({tag, " c0 stall"},   {31'b0, stall},   32'h0);
            chk({tag, " c0 Direc"},   {24'b0, Direc},   {24'b0, idx});
            chk({tag, " c0 Datain"},  Datain,           v.exp);
        end else begin
            chk({tag, " c0 LeerMem"}, {31'b0, LeerMem}, 32'h1);
            chk({tag, " c0 EscrMem"}, {31'b0, EscrMem}, 32'h0);
            chk({tag, " c0 stall"},   {31'b0, stall},   32'h1);
            chk({tag, " c0 Direc"},   {24'b0, Direc},   {24'b0, idx});
            chk({tag, " c0 err"},     {31'b0, acc_err}, 32'h0);
            @(negedge clk);
            chk({tag, " c1 stall"},   {31'b0, stall},   32'h0);
            chk({tag, " c1 LeerMem"}, {31'b0, LeerMem}, 32'h0);
            if (v.wr) begin
                chk({tag, " c1 EscrMem"}, {31'b0, EscrMem}, 32'h1);
                chk({tag, " c1 Direc"},   {24'b0, Direc},   {24'b0, idx});
                chk({tag, " c1 Datain"},  Datain,           v.exp);
            end else begin
                chk({tag, " c1 EscrMem"}, {31'b0, EscrMem},     32'h0);
                chk({tag, " c1 rvalid"},  {31'b0, rdata_valid}, 32'h1);
                chk({tag, " c1 rdata"},   rdata,                v.exp);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lo,
                                               input logic [1:0] sz, input logic sg);
        logic [31:0] s;
        s = w >> (lo * 8);
        if (sz == 2'b00) begin
            s = s & 32'hFF;
            if (sg && s[7]) s = s | 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            s = s & 32'hFFFF;
            if (sg && s[15]) s = s | 32'hFFFF0000;
        end
        return s;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] lo,
                                                input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] m;
        m = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFFFFFF;
        m = m << (lo * 8);
        return (w & ~m) | ((d << (lo * 8)) & m);
    endfunction

    logic [31:0] refm [16];

    initial begin
        vec_t v;
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) refm[i] = 32'h0;

        //           wr  size   sg  addr       wdata         err exp
        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 2'b00, 1'b1, 32'h013, 32'h0,        1'b0, 32'hFFFFFFDE};
        tbl[2]  = '{1'b0, 2'b01, 1'b0, 32'h012, 32'h0,        1'b0, 32'h0000DEAD};
        tbl[3]  = '{1'b1, 2'b00, 1'b0, 32'h011, 32'h00000055, 1'b0, 32'hDEAD55EF};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        1'b0, 32'hDEAD55EF};
        tbl[5]  = '{1'b0, 2'b01, 1'b0, 32'h013, 32'h0,        1'b1, 32'h0};
        tbl[6]  = '{1'b1, 2'b10, 1'b0, 32'h402, 32'h12345678, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 2'b11, 1'b0, 32'h010, 32'h0,        1'b1, 32'h0};
        tbl[8]  = '{1'b0, 2'b00, 1'b0, 32'h010, 32'h0,        1'b0, 32'h000000EF};
        tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h012, 32'hAAAA1234, 1'b0, 32'h123455EF};
        tbl[10] = '{1'b1, 2'b01, 1'b0, 32'h010, 32'h00008001, 1'b0, 32'h12348001};
        tbl[11] = '{1'b0, 2'b01, 1'b1, 32'h010, 32'h0,        1'b0, 32'hFFFF8001};
        tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0};
        tbl[13] = '{1'b1, 2'b00, 1'b0, 32'h3FF, 32'h00000077, 1'b0, 32'h77000000};
        tbl[14] = '{1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h77000000};
        tbl[15] = '{1'b0, 2'b00, 1'b1, 32'h012, 32'h0,        1'b0, 32'h00000034};

        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;
        @(negedge clk);
        chk("reset stall",   {31'b0, stall},       32'h0);
        chk("reset strobes", {30'b0, EscrMem, LeerMem}, 32'h0);
        chk("reset rvalid",  {31'b0, rdata_valid}, 32'h0);
        chk("reset err",     {31'b0, acc_err},     32'h0);
        chk("reset rdata",   rdata,                32'h0);
        chk("reset Direc",   {24'b0, Direc},       32'h0);
        chk("reset Datain",  Datain,               32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // rdata holds after the load; idle produces no strobes or stall.
        @(negedge clk);
        chk("hold rdata",   rdata,                32'h00000034);
        chk("hold rvalid",  {31'b0, rdata_valid}, 32'h0);
        chk("idle strobes", {30'b0, EscrMem, LeerMem}, 32'h0);
        chk("idle stall",   {31'b0, stall},       32'h0);
        @(posedge clk);
        #1;

        // Random mix in words 0x20..0x2F against a bench-side reference.
        for (int k = 0; k < 30; k++) begin
            logic [31:0] a;
            int          wi;
            v.wr    = 1'($urandom_range(0, 1));
            v.size  = 2'($urandom_range(0, 2));
            v.sgn   = 1'($urandom_range(0, 1));
            a       = 32'h80 + 32'($urandom_range(0, 63));
            if (v.size == 2'b01) a[0] = 1'b0;
            if (v.size == 2'b10) a[1:0] = 2'b00;
            v.addr  = a;
            v.wdata = $urandom;
            v.err   = 1'b0;
            wi      = int'(a[5:2]);
            if (v.wr) begin
                v.exp    = model_merge(refm[wi], a[1:0], v.size, v.wdata);
                refm[wi] = v.exp;
            end else begin
                v.exp = model_load(refm[wi], a[1:0], v.size, v.sgn);
            end
            apply(v, $sformatf("rnd%0d", k));
        end

        // Reset during the merge cycle of a byte store must suppress the write.
        v = '{1'b1, 2'b10, 1'b0, 32'h020, 32'h11223344, 1'b0, 32'h11223344};
        apply(v, "pre_rst_store");
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h020; req_wdata = 32'h00000099;
        @(negedge clk);
        chk("rmw c0 LeerMem", {31'b0, LeerMem}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst EscrMem", {31'b0, EscrMem},     32'h0);
        chk("rst LeerMem", {31'b0, LeerMem},     32'h0);
        chk("rst stall",   {31'b0, stall},       32'h0);
        chk("rst rvalid",  {31'b0, rdata_valid}, 32'h0);
        chk("rst rdata",   rdata,                32'h0);
        chk("rst Datain",  Datain,               32'h0);
        chk("rst Direc",   {24'b0, Direc},       32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst word08 kept", mem[8], 32'h11223344);
        @(posedge clk);
        #1 rst = 1'b0;
        v = '{1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 1'b0, 32'h11223344};
        apply(v, "post_rst_load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
